// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake with a fixed
// accept-to-response latency, modelling a slow memory seen by a CPU.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request captured, latency down-counter running
// RESP  | response presented until resp_ready consumes it
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Accept edge loads LATENCY-1 so the terminal count lands on edge LATENCY.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   mem [2**AW];

  logic accept;
  logic commit;
  logic unused_addr_bits;

  // Byte bit 0 and bits above AW are don't-care: higher addresses alias.
  assign unused_addr_bits = ^req_addr;

  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign commit     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          wr_d    = req_wr;
          addr_d  = req_addr[AW:1];
          wdata_d = req_wdata;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = wr_q ? 16'h0000 : mem[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 16'h0000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdata_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; reset only aborts a pending commit.
  always_ff @(posedge clk) begin
    if (commit && wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a word-array
// reference model with address aliasing and fixed response latency.
module tb_mem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  int          written_q[$];

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT), .AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [15:0] addr);
    return (int'(addr) / 2) % DEPTH;
  endfunction

  // One full transaction; request inputs are scrambled after accept and
  // resp_ready toggles randomly while the response is not yet due.
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                     input int hold, input logic hold_valid);
    int          idx;
    int          edges;
    logic [15:0] exp;
    idx = word_of(addr);
    exp = wr ? 16'h0000 : mem_m[idx];
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("resp_valid_early", resp_valid, 0);
    edges = 0;
    while (!resp_valid && edges < 20) begin
      req_addr   = 16'($urandom);
      req_wdata  = 16'($urandom);
      req_wr     = 1'($urandom);
      resp_ready = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, LAT);
    chk("resp_rdata", resp_rdata, exp);
    if (wr) begin
      mem_m[idx] = wdata;
      if (!known_m[idx]) written_q.push_back(idx);
      known_m[idx] = 1'b1;
    end
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = hold_valid;
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, exp);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_done", resp_valid, 0);
    chk("rdata_zero_idle", resp_rdata, 0);
    chk("busy_done", busy, 0);
    chk("req_ready_done", req_ready, 1);
  endtask

  initial begin
    int          idx;
    logic [15:0] a;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_ready_after_rst", req_ready, 1);

    // Write then read back, including the odd-byte alias.
    txn(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
    txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    txn(1'b0, 16'h0011, 16'h0000, 0, 1'b0);

    // Stalled response with a competing request held high.
    txn(1'b0, 16'h0010, 16'h0000, 10, 1'b1);

    // Write aborted by reset before its commit edge.
    txn(1'b1, 16'h0020, 16'h1234, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'hAAAA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_resp", resp_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("abort_req_ready_release", req_ready, 1);
    txn(1'b0, 16'h0020, 16'h0000, 0, 1'b0);

    // Aliasing above the storage depth.
    txn(1'b1, 16'h0200, 16'h5A5A, 0, 1'b0);
    txn(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

    // Randomized mix; reads use only words already written, via random aliases.
    for (int n = 0; n < 40; n++) begin
      if (($urandom % 2 == 0) || written_q.size() == 0) begin
        txn(1'b1, 16'($urandom), 16'($urandom), $urandom_range(0, 2), 1'($urandom));
      end else begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a   = 16'(($urandom_range(0, 127) * 512) + (idx * 2) + ($urandom % 2));
        txn(1'b0, a, 16'($urandom), $urandom_range(0, 2), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 4, meaning the number of clock edges from request accept to response valid (legal range 2..15).
REQ-002 The module SHALL have parameter AW, default 8, meaning the log2 of storage depth in 16-bit words.
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 The module SHALL have port req_valid  input  1  meaning the CPU presents a request.
REQ-006 The module SHALL have port req_ready  output  1  meaning the responder can accept a request this cycle.
REQ-007 The module SHALL have port req_wr  input  1  meaning 1 = write, 0 = read.
REQ-008 The module SHALL have port req_addr  input  16  meaning the byte address.
REQ-009 The module SHALL have port req_wdata  input  16  meaning the write data.
REQ-010 The module SHALL have port resp_valid  output  1  meaning the response is available.
REQ-011 The module SHALL have port resp_ready  input  1  meaning the CPU consumes the response.
REQ-012 The module SHALL have port resp_rdata  output  16  meaning the read data, or 0 for a write acknowledge.
REQ-013 The module SHALL have port busy  output  1  meaning the responder is in any state other than IDLE.

Function
REQ-014 Storage SHALL be 2^AW words of 16 bits, indexed by req_addr[AW:1]; req_addr[0] and bits above AW SHALL be ignored, so higher addresses alias.
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; the module SHALL capture req_wr, req_addr and req_wdata internally and move to WAIT.
REQ-017 Request inputs SHALL be ignored after accept; later changes to them SHALL NOT affect the transaction in flight.
REQ-018 In WAIT, a down-counter SHALL count so that the module enters RESP exactly LATENCY edges after the accept edge; accept at edge 0 SHALL give resp_valid=1 after edge LATENCY.
REQ-019 A write SHALL commit to storage on the edge that enters RESP, not earlier.
REQ-020 A read SHALL sample storage on the edge that enters RESP and SHALL register the result into resp_rdata.
REQ-021 In RESP, resp_valid SHALL be 1 and resp_rdata SHALL hold stable until a rising edge with resp_ready=1, which SHALL return the FSM to IDLE.
REQ-022 If resp_ready is held low, RESP SHALL persist indefinitely and no new request SHALL be accepted.
REQ-023 resp_ready SHALL be ignored outside RESP.
REQ-024 resp_rdata SHALL be 0 whenever resp_valid=0; for write transactions, resp_rdata SHALL be 0 in RESP.
REQ-025 The minimum spacing between accepts SHALL be LATENCY+2 edges (accept, LATENCY edges to RESP, 1 edge to consume, 1 edge in IDLE).
REQ-026 A read that follows a completed write to the same word SHALL return the written data.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force the FSM to IDLE, the counter to 0, resp_valid=0, resp_rdata=0, busy=0 and req_ready=0 while reset is held.
REQ-028 req_ready SHALL go to 1 in the first cycle after rst_n deasserts.
REQ-029 Storage contents SHALL NOT be cleared by reset, and their power-up value is undefined.
REQ-030 A write aborted by reset before the commit edge SHALL leave storage unchanged; a read aborted by reset SHALL produce no response.

Verification
REQ-031 With LATENCY=4, write 0xBEEF to address 0x0010 with resp_ready=1 -> resp_valid high exactly 4 edges after accept, resp_rdata=0, and busy low one edge later.
REQ-032 Read address 0x0010 after the write in REQ-031 -> resp_valid high after 4 edges with resp_rdata=0xBEEF; a read of address 0x0011 (aliased odd byte) SHALL also return 0xBEEF.
REQ-033 Hold resp_ready=0 for 10 cycles during RESP on a read while driving req_valid=1 -> resp_valid and resp_rdata stay stable, req_ready stays 0, and no second accept occurs until resp_ready pulses.
REQ-034 Write 0x1234 to address 0x0020, then write 0xAAAA to 0x0020 but assert rst_n=0 at edge 2 after accept; then read 0x0020 -> returns 0x1234.
REQ-035 After accept, change req_addr and req_wdata every cycle -> the captured address and data are used, and storage at the other addresses is unchanged.
REQ-036 With AW=8, write 0x5A5A to address 0x0200, then read address 0x0000 -> returns 0x5A5A (aliasing).
